fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the 64-bit RISC-V core. It owns the PC, issues word requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small FIFO. It presents instructions to decode with a valid/ready handshake, exporting the opcode field that drives the main control decoder. It also accepts PC redirects (JALR and branch targets) from execute and discards any stale in-flight fetch.

## Interface
Parameters:
- XLEN, 64: PC/address width.
- RESET_PC, 64'h0: first fetch address after reset.
- BUF_DEPTH, 2: instruction FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address, equal to the current PC.
- imem_rsp_valid  in  1  response valid for one cycle; no backpressure.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle PC redirect from execute.
- redirect_pc  in  XLEN  redirect target.
- dec_valid  out  1  FIFO head valid.
- dec_ready  in  1  decode consumes the head.
- dec_instr  out  32  head instruction; 32'h00000013 (NOP) when empty.
- dec_pc  out  XLEN  head PC; 0 when empty.
- dec_opcode  out  7  dec_instr[6:0]; feeds the control decoder.
- fetch_misaligned  out  1  present only with FETCH_MISALIGN_EN.

## Operation
- States: IDLE, REQ, WAIT, DROP. At most one request outstanding.
- IDLE: entered for exactly one cycle after reset, then moves to REQ.
- REQ: imem_req_valid = space && !redirect_valid, where space = (fifo_count < BUF_DEPTH).
  - On handshake: PC += 4 and the state moves to WAIT.
  - imem_req_addr must hold stable while valid is high and ready is low.
- WAIT: on imem_rsp_valid, push {PC of request, data} into the FIFO and move to REQ.
- DROP: on imem_rsp_valid, discard the response and move to REQ.
- Redirect has highest priority, in any state:
  - Flush the FIFO (count=0, dec_valid=0 next cycle) and set PC to redirect_pc.
  - If in WAIT or DROP, move to DROP; otherwise move to REQ.
  - A response arriving in the redirect cycle is discarded.
- Pop occurs when dec_valid && dec_ready. A push and a pop in the same cycle leave the count unchanged.
- The FIFO cannot overflow because a request is issued only when there is space and responses are single-outstanding. Count is reserved at request time: space = (count + outstanding) < BUF_DEPTH.
- PC arithmetic is modulo 2^XLEN; wrap-around at the top of the address space is permitted and silent.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, FIFO empty, imem_req_valid=0, dec_valid=0, dec_instr=NOP, dec_opcode=7'h13, dec_pc=0, fetch_misaligned=0.
- Timeline after reset: reset deasserts at edge N, the state is IDLE in cycle N, and imem_req_valid first goes high in cycle N+1 with addr=RESET_PC.
- Response to dec_valid latency is 1 cycle (registered push, no bypass).
- Peak throughput is one instruction per 2 cycles with a 1-cycle memory.
- Redirect at edge R: the first request to redirect_pc appears in cycle R+1 if no fetch is in flight, otherwise in the cycle after the stale response is dropped.
- Asserting rst_n low mid-operation aborts everything. Any response arriving during or after reset while in IDLE is ignored.

## Configuration
- FETCH_MISALIGN_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_misaligned (sticky).
  - The FIFO is flushed and fetching halts (state REQ, imem_req_valid=0).
  - Fetching resumes only after an aligned redirect, which also clears the flag.
- FETCH_MISALIGN_EN undefined: the port is absent and redirect_pc[1:0] is forced to 2'b00.

## Structure
- fetch_pkg holds:
  - The state enum {IDLE, REQ, WAIT, DROP}.
  - INSN_NOP = 32'h00000013.
  - OPCODE_W = 7 and INSN_W = 32.
- Sub-module fetch_buffer is a parameterized synchronous FIFO (data width INSN_W+XLEN, depth BUF_DEPTH) with push, pop, flush, count, and head outputs.
- The top level holds the PC, the FSM, and the outstanding/reservation logic.

## Test plan
- Reset, then memory with ready=1 and 1-cycle response: addresses 0,4,8 in sequence; dec_pc follows 0,4,8 and dec_opcode matches the returned words.
- dec_ready=0 with BUF_DEPTH=2: exactly 2 requests are accepted, then imem_req_valid=0; a single pop re-enables exactly one request.
- imem_req_ready held low for 5 cycles: addr stays 0 and stable, and the PC does not advance.
- Redirect to 0x100 while in WAIT (fetch of 0x8 outstanding): the 0x8 response is dropped, the FIFO is empty, and the next request has addr=0x100.
- Redirect in the same cycle as a response and a pop: the FIFO is flushed, and the first dec_pc after that is the target.
- With FETCH_MISALIGN_EN: redirect to 0x102 sets fetch_misaligned and produces no requests; redirect to 0x200 clears the flag and the next request has addr=0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam int INSN_W   = 32;
    localparam int OPCODE_W = 7;

    localparam logic [INSN_W-1:0] INSN_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous FIFO holding fetched {pc, instruction} entries
module fetch_buffer #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV64 fetch stage: PC, single-outstanding fetch FSM, redirects
// Optional FETCH_MISALIGN_EN: misaligned redirects raise a sticky flag and halt fetching.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSN_W-1:0]   imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [INSN_W-1:0]   dec_instr,
    output logic [XLEN-1:0]     dec_pc,
    output logic [OPCODE_W-1:0] dec_opcode
`ifdef FETCH_MISALIGN_EN
    ,
    output logic                fetch_misaligned
`endif
);
    localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int ENTRY_W = XLEN + INSN_W;

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic [XLEN-1:0]  redir_target;
    logic             halted;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W:0]   reserved;
    logic             outstanding, space, req_valid;
    logic             buf_push, buf_pop, buf_flush, buf_empty;
    logic [ENTRY_W-1:0] buf_head;

`ifdef FETCH_MISALIGN_EN
    logic misaligned_q, misaligned_d;

    assign redir_target     = redirect_pc;
    assign halted           = misaligned_q;
    assign fetch_misaligned = misaligned_q;

    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            misaligned_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir_target         = {redirect_pc[XLEN-1:2], 2'b00};
    assign halted               = 1'b0;
`endif

    // FIFO slots are reserved at request time so a returning word always fits.
    assign outstanding = (state_q == WAIT) || (state_q == DROP);
    assign reserved    = {1'b0, buf_count} + {{CNT_W{1'b0}}, outstanding};
    assign space       = reserved < (CNT_W + 1)'(BUF_DEPTH);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        req_valid = 1'b0;
        buf_push  = 1'b0;
        buf_flush = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                req_valid = space && !redirect_valid && !halted;
                if (req_valid && imem_req_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    buf_push = 1'b1;
                    state_d  = REQ;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        // A response landing in the redirect cycle retires the stale fetch, so no DROP is needed.
        if (redirect_valid) begin
            buf_flush = 1'b1;
            buf_push  = 1'b0;
            pc_d      = redir_target;
            if (outstanding && !imem_rsp_valid) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign buf_pop = !buf_empty && dec_ready;

    fetch_buffer #(
        .DATA_W (ENTRY_W),
        .DEPTH  (BUF_DEPTH),
        .CNT_W  (CNT_W)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data ({req_pc_q, imem_rsp_data}),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .count     (buf_count),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign dec_valid      = !buf_empty;
    assign dec_instr      = buf_empty ? INSN_NOP : buf_head[INSN_W-1:0];
    assign dec_pc         = buf_empty ? '0 : buf_head[ENTRY_W-1:INSN_W];
    assign dec_opcode     = dec_instr[OPCODE_W-1:0];

endmodule
